// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: rate prescaler and sequencer for a circular LED shift register.
// Ports: clock, i_reset (sync, active-high), i_enable, i_sel_rate[1:0], i_dir in;
//   o_valid (shift strobe), o_sr_reset (reload pulse), o_dir, o_pos, o_state[1:0] out.
// Option: define LED_SHIFT_CTRL_PINGPONG_EN to bounce the lit LED end to end.
module led_shift_ctrl #(
   parameter int          NB_LEDS    = 4,
   parameter int          NB_COUNTER = 32,
   parameter int unsigned R0         = 2**23-1,
   parameter int unsigned R1         = 2**24-1,
   parameter int unsigned R2         = 2**25-1,
   parameter int unsigned R3         = 2**26-1
) (
   input  logic                       clock,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic [1:0]                 i_sel_rate,
   input  logic                       i_dir,
   output logic                       o_valid,
   output logic                       o_sr_reset,
   output logic                       o_dir,
   output logic [$clog2(NB_LEDS)-1:0] o_pos,
   output logic [1:0]                 o_state
);

   localparam int PW = $clog2(NB_LEDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Last o_pos value of a sweep before wrapping back to 0.
`ifdef LED_SHIFT_CTRL_PINGPONG_EN
   localparam logic [PW-1:0] POS_LAST = PW'(NB_LEDS-2);
   logic unused_dir;
   assign unused_dir = i_dir;
`else
   localparam logic [PW-1:0] POS_LAST = PW'(NB_LEDS-1);
`endif

   state_t                  state_q, state_d;
   logic [NB_COUNTER-1:0]   counter_q, counter_d;
   logic                    valid_q, valid_d;
   logic                    sr_reset_q, sr_reset_d;
   logic                    dir_q, dir_d;
   logic [PW-1:0]           pos_q, pos_d;
   logic [NB_COUNTER-1:0]   limit;

   // Rate select is combinational so a mid-count change applies at once.
   always_comb begin
      limit = NB_COUNTER'(R0);
      unique case (i_sel_rate)
         2'd0: limit = NB_COUNTER'(R0);
         2'd1: limit = NB_COUNTER'(R1);
         2'd2: limit = NB_COUNTER'(R2);
         2'd3: limit = NB_COUNTER'(R3);
         default: limit = NB_COUNTER'(R0);
      endcase
   end

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      valid_d    = 1'b0;
      sr_reset_d = 1'b0;
      dir_d      = dir_q;
      pos_d      = pos_q;
      unique case (state_q)
         IDLE: begin
            counter_d = '0;
            if (i_enable) begin
               state_d    = LOAD;
               sr_reset_d = 1'b1;
               pos_d      = '0;
`ifdef LED_SHIFT_CTRL_PINGPONG_EN
               dir_d      = 1'b0;
`else
               dir_d      = i_dir;
`endif
            end
         end
         LOAD: begin
            state_d   = RUN;
            counter_d = '0;
         end
         RUN: begin
            if (!i_enable) begin
               state_d   = IDLE;
               counter_d = '0;
            end else if (counter_q >= limit) begin
               counter_d = '0;
               valid_d   = 1'b1;
               if (pos_q == POS_LAST) begin
                  pos_d = '0;
`ifdef LED_SHIFT_CTRL_PINGPONG_EN
                  // End of a sweep: reverse the bounce.
                  dir_d = ~dir_q;
`endif
               end else begin
                  pos_d = pos_q + PW'(1);
               end
`ifndef LED_SHIFT_CTRL_PINGPONG_EN
               dir_d = i_dir;
`endif
            end else begin
               counter_d = counter_q + NB_COUNTER'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            counter_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         valid_q    <= 1'b0;
         sr_reset_q <= 1'b0;
         dir_q      <= 1'b0;
         pos_q      <= '0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         valid_q    <= valid_d;
         sr_reset_q <= sr_reset_d;
         dir_q      <= dir_d;
         pos_q      <= pos_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_sr_reset = sr_reset_q;
   assign o_dir      = dir_q;
   assign o_pos      = pos_q;
   assign o_state    = state_q;

endmodule
